// File: rtl/complex_div_pkg.sv
// Shared types and helpers for the complex divider and its sibling complex multiplier.
package complex_div_pkg;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} cdiv_state_e;

  localparam int unsigned CPLX_W = 8;

  // Serial quotient bits needed for a (2W+1)-bit numerator shifted left by FRAC.
  function automatic int unsigned qbits(input int unsigned w, input int unsigned frac);
    return 2 * w + frac + 1;
  endfunction

  function automatic logic [2*CPLX_W-1:0] cplx_pack(input logic signed [CPLX_W-1:0] re,
                                                    input logic signed [CPLX_W-1:0] im);
    return {re, im};
  endfunction

  function automatic logic signed [CPLX_W-1:0] cplx_re(input logic [2*CPLX_W-1:0] z);
    return z[2*CPLX_W-1 -: CPLX_W];
  endfunction

  function automatic logic signed [CPLX_W-1:0] cplx_im(input logic [2*CPLX_W-1:0] z);
    return z[CPLX_W-1:0];
  endfunction

endpackage

// File: rtl/restoring_div_core.sv
// Unsigned serial restoring divider: one quotient bit per step, dividend shifted out MSB-first.
module restoring_div_core #(
  parameter int unsigned N = 25,
  parameter int unsigned D = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [D-1:0] remainder
);

  logic [N-1:0] q_q, q_d;
  logic [D-1:0] rem_q, rem_d;
  logic [D:0]   trial;
  logic [D:0]   diff;

  // The quotient register doubles as the dividend shifter.
  always_comb begin
    q_d   = q_q;
    rem_d = rem_q;
    trial = {rem_q, q_q[N-1]};
    diff  = trial - {1'b0, divisor};
    if (load) begin
      q_d   = dividend;
      rem_d = '0;
    end else if (step) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = diff[D-1:0];
        q_d   = {q_q[N-2:0], 1'b1};
      end else begin
        rem_d = trial[D-1:0];
        q_d   = {q_q[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      rem_q <= '0;
    end else begin
      q_q   <= q_d;
      rem_q <= rem_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = rem_q;

endmodule

// File: rtl/complex_div.sv
// Sequential complex divider q = a / b with valid/ready handshakes.
// CDIV_ROUND_EN: one extra quotient bit, rounded half away from zero (+1 cycle latency).
module complex_div
  import complex_div_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned FRAC = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] quotient,
  output logic           div_by_zero,
  output logic           sat
);

`ifdef CDIV_ROUND_EN
  localparam int unsigned RND = 1;
`else
  localparam int unsigned RND = 0;
`endif
  localparam int unsigned NW  = 2 * W + 1;
  localparam int unsigned OW  = 2 * W;
  localparam int unsigned QB  = qbits(W, FRAC);
  localparam int unsigned DB  = QB + RND;
  localparam int unsigned CW  = $clog2(DB);

  localparam logic [DB:0]   POS_LIM = (DB+1)'((64'd1 << (OW - 1)) - 64'd1);
  localparam logic [DB:0]   NEG_LIM = POS_LIM + (DB+1)'(1);
  localparam logic [OW-1:0] MAX_V   = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MIN_V   = {1'b1, {(OW-1){1'b0}}};

  cdiv_state_e     state_q, state_d;
  logic [2*W-1:0]  a_q, a_d, b_q, b_d;
  logic [NW-1:0]   den_q, den_d;
  logic            neg_re_q, neg_re_d, neg_im_q, neg_im_d;
  logic            dbz_q, dbz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [4*W-1:0]  quotient_q, quotient_d;
  logic            div_by_zero_q, div_by_zero_d;
  logic            sat_q, sat_d;

  logic signed [W-1:0]   ar, ai, br, bi;
  logic signed [2*W-1:0] p_ac, p_bd, p_bc, p_ad, p_cc, p_dd;
  logic signed [NW-1:0]  num_re, num_im;
  logic [NW-1:0]         den_c, mag_re, mag_im;
  logic [DB-1:0]         dvd_re, dvd_im, q_re, q_im;
  logic [NW-1:0]         unused_rem_re, unused_rem_im;
  logic [DB:0]           fm_re, fm_im;
  logic [OW:0]           cl_re, cl_im;
  logic                  load, step;

  // Sign-and-clamp of a quotient magnitude; MSB of the result flags a clamp.
  function automatic logic [OW:0] clamp(input logic neg, input logic [DB:0] mag);
    logic [DB:0] negm;
    negm = -mag;
    if (neg) begin
      if (mag > NEG_LIM) return {1'b1, MIN_V};
      return {1'b0, negm[OW-1:0]};
    end
    if (mag > POS_LIM) return {1'b1, MAX_V};
    return {1'b0, mag[OW-1:0]};
  endfunction

  // Numerators, shared denominator and divider loads from the registered operands.
  always_comb begin
    ar     = a_q[2*W-1:W];
    ai     = a_q[W-1:0];
    br     = b_q[2*W-1:W];
    bi     = b_q[W-1:0];
    p_ac   = (2*W)'(ar) * (2*W)'(br);
    p_bd   = (2*W)'(ai) * (2*W)'(bi);
    p_bc   = (2*W)'(ai) * (2*W)'(br);
    p_ad   = (2*W)'(ar) * (2*W)'(bi);
    p_cc   = (2*W)'(br) * (2*W)'(br);
    p_dd   = (2*W)'(bi) * (2*W)'(bi);
    num_re = NW'(p_ac) + NW'(p_bd);
    num_im = NW'(p_bc) - NW'(p_ad);
    den_c  = NW'($unsigned(p_cc)) + NW'($unsigned(p_dd));
    mag_re = num_re[NW-1] ? NW'(-num_re) : NW'(num_re);
    mag_im = num_im[NW-1] ? NW'(-num_im) : NW'(num_im);
    dvd_re = DB'(mag_re) << (FRAC + RND);
    dvd_im = DB'(mag_im) << (FRAC + RND);
  end

  // Guard-bit rounding (when enabled) happens on the magnitude before clamping.
  always_comb begin
`ifdef CDIV_ROUND_EN
    fm_re = (DB+1)'(q_re >> 1) + (DB+1)'(q_re[0]);
    fm_im = (DB+1)'(q_im >> 1) + (DB+1)'(q_im[0]);
`else
    fm_re = (DB+1)'(q_re);
    fm_im = (DB+1)'(q_im);
`endif
    cl_re = clamp(neg_re_q, fm_re);
    cl_im = clamp(neg_im_q, fm_im);
  end

  assign load = (state_q == PREP);
  assign step = (state_q == DIV);

  restoring_div_core #(.N(DB), .D(NW)) u_div_re (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .dividend  (dvd_re),
    .divisor   (den_q),
    .quotient  (q_re),
    .remainder (unused_rem_re)
  );

  restoring_div_core #(.N(DB), .D(NW)) u_div_im (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .dividend  (dvd_im),
    .divisor   (den_q),
    .quotient  (q_im),
    .remainder (unused_rem_im)
  );

  // Control FSM next-state and registered outputs.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    den_d         = den_q;
    neg_re_d      = neg_re_q;
    neg_im_d      = neg_im_q;
    dbz_d         = dbz_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    quotient_d    = quotient_q;
    div_by_zero_d = div_by_zero_q;
    sat_d         = sat_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = PREP;
        end
      end
      PREP: begin
        den_d    = den_c;
        neg_re_d = num_re[NW-1];
        neg_im_d = num_im[NW-1];
        cnt_d    = CW'(DB - 1);
        dbz_d    = (den_c == '0);
        state_d  = (den_c == '0) ? DONE : DIV;
      end
      DIV: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d   = 1'b1;
          div_by_zero_d = dbz_q;
          quotient_d    = dbz_q ? '0 : {cl_re[OW-1:0], cl_im[OW-1:0]};
          sat_d         = !dbz_q && (cl_re[OW] || cl_im[OW]);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      den_q         <= '0;
      neg_re_q      <= 1'b0;
      neg_im_q      <= 1'b0;
      dbz_q         <= 1'b0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      div_by_zero_q <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      den_q         <= den_d;
      neg_re_q      <= neg_re_d;
      neg_im_q      <= neg_im_d;
      dbz_q         <= dbz_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      quotient_q    <= quotient_d;
      div_by_zero_q <= div_by_zero_d;
      sat_q         <= sat_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign div_by_zero = div_by_zero_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_complex_div.sv
// Directed self-checking bench for complex_div (W=8, FRAC=8).
module tb_complex_div;
  import complex_div_pkg::*;

`ifdef CDIV_ROUND_EN
  localparam int          LAT = 28;
  localparam logic [31:0] RP  = 32'h00AB0000;
  localparam logic [31:0] RN  = 32'hFF550000;
`else
  localparam int          LAT = 27;
  localparam logic [31:0] RP  = 32'h00AA0000;
  localparam logic [31:0] RN  = 32'hFF560000;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;
  logic        sat;

  int checks = 0;
  int errors = 0;

  complex_div #(.W(8), .FRAC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .sat         (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, time out_valid from the accept edge, check outputs,
  // and complete the handshake when out_ready is high.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int exp_lat, input logic [31:0] exp_q,
                        input logic exp_dbz, input logic exp_sat);
    int lat;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    lat      = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_quotient"}, quotient, exp_q);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    check({tag, "_sat"}, 32'(sat), 32'(exp_sat));
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("basic", cplx_pack(8'sd2, 8'sd4), cplx_pack(8'sd1, 8'sd1), LAT, 32'h03000100, 1'b0, 1'b0);
    run_op("signed", 16'hF800, 16'h0002, LAT, 32'h00000400, 1'b0, 1'b0);
    run_op("saturate", 16'h8080, 16'h0001, LAT, 32'h80007FFF, 1'b0, 1'b1);
    run_op("div_zero", 16'h1234, 16'h0000, 2, 32'h00000000, 1'b1, 1'b0);
    run_op("round_pos", 16'h0200, 16'h0300, LAT, RP, 1'b0, 1'b0);
    run_op("round_neg", 16'hFE00, 16'h0300, LAT, RN, 1'b0, 1'b0);

    // Backpressure: result must hold while new operands are offered and ignored.
    out_ready = 1'b0;
    run_op("bp", 16'h0204, 16'h0101, LAT, 32'h03000100, 1'b0, 1'b0);
    in_valid = 1'b1;
    a        = 16'h1111;
    b        = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_quotient", quotient, 32'h03000100);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of the divide phase.
    a        = 16'h0204;
    b        = 16'h0101;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_quotient", quotient, 32'd0);
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("mid_rst_no_result", 32'(out_valid), 32'd0);

    run_op("after_rst", 16'hF800, 16'h0002, LAT, 32'h00000400, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
